sort4_stream_ctrl: RTL and testbench



---
 rtl/sort4_stream_ctrl_pkg.sv | 8 +
 rtl/sortingNetwork4.sv | 19 +
 rtl/sort4_stream_ctrl.sv | 72 +++++++
 tb/tb_sort4_stream_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/sort4_stream_ctrl_pkg.sv
// sort4_stream_ctrl_pkg: shared width default, FSM encoding and pad constant
package sort4_stream_ctrl_pkg;
  localparam int W_DEFAULT = 16;
  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] SORT = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [W_DEFAULT-1:0] PAD = '1;
endpackage

// File: rtl/sortingNetwork4.sv
// sortingNetwork4: combinational 4-lane ascending sorter, packed {y3,y2,y1,y0}
module sortingNetwork4 #(
  parameter int WIDTH = 16
) (
  input  logic [4*WIDTH-1:0] x,
  output logic [4*WIDTH-1:0] y
);
  logic [WIDTH-1:0] x0, x1, x2, x3, a0, a1, a2, a3, b0, b1, b2, b3;
  assign {x3, x2, x1, x0} = x;
  assign a0 = x0 < x1 ? x0 : x1;
  assign a1 = x0 < x1 ? x1 : x0;
  assign a2 = x2 < x3 ? x2 : x3;
  assign a3 = x2 < x3 ? x3 : x2;
  assign b0 = a0 < a2 ? a0 : a2;
  assign b2 = a0 < a2 ? a2 : a0;
  assign b1 = a1 < a3 ? a1 : a3;
  assign b3 = a1 < a3 ? a3 : a1;
  assign y = {b3, (b1 < b2 ? b2 : b1), (b1 < b2 ? b1 : b2), b0};
endmodule

// File: rtl/sort4_stream_ctrl.sv
// sort4_stream_ctrl: collects up to four words, sorts them once, replays them ascending
module sort4_stream_ctrl
  import sort4_stream_ctrl_pkg::*;
#(
  parameter int WIDTH = W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);
  localparam logic [WIDTH-1:0] PAD_W = '1;
  logic [1:0] state, idx, k;
  logic [2:0] n;
  logic [WIDTH-1:0] slot [4];
  logic [WIDTH-1:0] sorted [4];
  logic [4*WIDTH-1:0] net_x, net_y;
  logic last_beat;
  // lanes beyond the group size carry all-ones so they sort to the top
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign net_x[i*WIDTH +: WIDTH] = 3'(i) < n ? slot[i] : PAD_W;
  end
  sortingNetwork4 #(.WIDTH(WIDTH)) u_net (.x(net_x), .y(net_y));
  assign last_beat = {1'b0, k} == n - 3'd1;
  assign in_ready = state == FILL;
  assign out_valid = state == DRAIN;
  assign busy = state == SORT || state == DRAIN;
  assign out_data = out_valid ? sorted[k] : '0;
  assign out_last = out_valid && last_beat;
  // fill, capture the network result for one cycle, then drain the real lanes
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      idx <= '0;
      k <= '0;
      n <= '0;
      for (int i = 0; i < 4; i++) begin
        slot[i] <= '0;
        sorted[i] <= '0;
      end
    end else begin
      case (state)
        FILL: if (in_valid) begin
          slot[idx] <= in_data;
          idx <= idx + 2'd1;
          if (idx == 2'd3 || in_last) begin
            n <= {1'b0, idx} + 3'd1;
            state <= SORT;
          end
        end
        SORT: begin
          for (int i = 0; i < 4; i++) sorted[i] <= net_y[i*WIDTH +: WIDTH];
          idx <= '0;
          k <= '0;
          state <= DRAIN;
        end
        DRAIN: if (out_ready) begin
          if (last_beat) state <= FILL;
          else k <= k + 2'd1;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_sort4_stream_ctrl.sv
// tb_sort4_stream_ctrl: directed and randomized groups checked against a sorted-queue model
module tb_sort4_stream_ctrl;
  typedef logic [15:0] wq_t[$];
  logic clk = 1'b0;
  logic rst;
  logic [15:0] in_data, out_data;
  logic in_valid, in_last, in_ready, out_valid, out_last, out_ready, busy;
  int vectors = 0;
  int miscompares = 0;
  wq_t q;
  always #5 clk = ~clk;
  sort4_stream_ctrl dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_last"}, 32'(out_last), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask
  task automatic send(input wq_t w, input bit gaps, input bit last4);
    for (int i = 0; i < w.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 0;
          in_data = 16'($urandom);
          in_last = 1'($urandom);
          tick;
          chk("fill_idle_ready", 32'(in_ready), 1);
        end
      end
      in_valid = 1;
      in_data = w[i];
      in_last = (i == w.size() - 1) && (w.size() < 4 || last4);
      chk("fill_ready", 32'(in_ready), 1);
      chk("fill_out_valid", 32'(out_valid), 0);
      tick;
    end
    in_valid = 0;
    in_last = 0;
    chk("sort_in_ready", 32'(in_ready), 0);
    chk("sort_out_valid", 32'(out_valid), 0);
    chk("sort_busy", 32'(busy), 1);
    tick;
  endtask
  task automatic recv(input wq_t w, input int stall_at, input int stall_len, input bit rnd, input int beats);
    wq_t e;
    int st;
    e = w;
    e.sort();
    for (int b = 0; b < beats; b++) begin
      st = rnd ? int'($urandom_range(0, 2)) : (b == stall_at ? stall_len : 0);
      for (int s = 0; s <= st; s++) begin
        out_ready = s == st;
        in_valid = (b == e.size() - 1 && s == st) ? 1'b0 : 1'($urandom);
        in_data = 16'($urandom);
        in_last = 1'($urandom);
        chk("drain_valid", 32'(out_valid), 1);
        chk("drain_data", 32'(out_data), 32'(e[b]));
        chk("drain_last", 32'(out_last), 32'(b == e.size() - 1));
        chk("drain_in_ready", 32'(in_ready), 0);
        chk("drain_busy", 32'(busy), 1);
        tick;
      end
    end
    in_valid = 0;
    in_last = 0;
    out_ready = 1;
  endtask
  initial begin
    rst = 1;
    in_valid = 0;
    in_last = 0;
    in_data = 0;
    out_ready = 1;
    tick;
    tick;
    idle_outputs("reset");
    rst = 0;
    q = '{16'h0030, 16'h0010, 16'h0040, 16'h0020};
    send(q, 0, 0);
    recv(q, -1, 0, 0, 4);
    idle_outputs("full_done");
    q = '{16'h0005, 16'h0003};
    send(q, 0, 0);
    recv(q, -1, 0, 0, 2);
    idle_outputs("partial_done");
    q = '{16'hFFFF, 16'h0001};
    send(q, 0, 0);
    recv(q, -1, 0, 0, 2);
    idle_outputs("pad_tie_done");
    q = '{16'h0004, 16'h0003, 16'h0002, 16'h0001};
    send(q, 0, 1);
    recv(q, 1, 3, 0, 4);
    idle_outputs("backpressure_done");
    q = '{16'h0007, 16'h0006, 16'h0005, 16'h0004};
    send(q, 0, 0);
    recv(q, -1, 0, 0, 1);
    rst = 1;
    tick;
    idle_outputs("reset_drain");
    rst = 0;
    q = '{16'h0009, 16'h0008};
    send(q, 0, 0);
    recv(q, -1, 0, 0, 2);
    idle_outputs("after_reset_done");
    q = '{16'h1234};
    send(q, 0, 0);
    recv(q, -1, 0, 0, 1);
    idle_outputs("single_done");
    for (int g = 0; g < 40; g++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(1, 4)); i++)
        q.push_back($urandom_range(0, 5) == 0 ? 16'hFFFF :
                    $urandom_range(0, 1) == 0 ? 16'($urandom_range(0, 7)) : 16'($urandom));
      send(q, 1, 1'($urandom));
      recv(q, -1, 0, 1, q.size());
      idle_outputs("random_done");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
